island_scheduler: RTL

- Sequences HDMI data-island periods inside video blanking.
- Arbitrates between up to NUM_REQ packet sources (audio sample, ACR, InfoFrames, etc.).
- Drives the packet assembler's header, sub and data_island_period inputs.
- Emits a period code so the TMDS channel mux selects control, preamble, guard band or packet data.

---
 rtl/hdmi_island_pkg.sv | 40 ++++
 rtl/island_arbiter.sv | 56 +++++
 rtl/island_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hdmi_island_pkg.sv
// Shared encodings, FSM state type and timing constants for the HDMI data-island scheduler.
package hdmi_island_pkg;

    // State values equal the period codes driven to the TMDS channel mux.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_LEAD_GB  = 3'd2,
        ST_PACKET   = 3'd3,
        ST_TRAIL_GB = 3'd4
    } island_state_t;

    localparam logic [2:0] PERIOD_CTRL     = 3'd0;
    localparam logic [2:0] PERIOD_PREAMBLE = 3'd1;
    localparam logic [2:0] PERIOD_LEAD_GB  = 3'd2;
    localparam logic [2:0] PERIOD_PACKET   = 3'd3;
    localparam logic [2:0] PERIOD_TRAIL_GB = 3'd4;

    localparam int PREAMBLE_LEN = 8;
    localparam int GB_LEN       = 2;
    localparam int PACKET_LEN   = 32;

    // Blanking needed to finish a packet plus trailing guard band, and a whole one-packet island.
    localparam int PACKET_MIN = PACKET_LEN + GB_LEN;
    localparam int ISLAND_MIN = PREAMBLE_LEN + GB_LEN + PACKET_MIN;

    function automatic logic [2:0] period_of(input island_state_t s);
        logic [2:0] code;
        code = PERIOD_CTRL;
        case (s)
            ST_PREAMBLE: code = PERIOD_PREAMBLE;
            ST_LEAD_GB:  code = PERIOD_LEAD_GB;
            ST_PACKET:   code = PERIOD_PACKET;
            ST_TRAIL_GB: code = PERIOD_TRAIL_GB;
            default:     code = PERIOD_CTRL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/island_arbiter.sv
// Packet-source arbiter: combinational winner search from a start pointer.
// ISLAND_SCHED_ROUND_ROBIN_EN makes the pointer rotate past each grant; otherwise it stays at 0 (fixed priority).
module island_arbiter
    import hdmi_island_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] search_idx;
    int               search_sum;

    // Walk offsets from the far end back to 0 so the nearest valid source after ptr_q wins.
    always_comb begin
        winner     = '0;
        any_valid  = 1'b0;
        search_idx = '0;
        search_sum = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            search_sum = int'(ptr_q) + i;
            if (search_sum >= NUM_REQ) begin
                search_sum = search_sum - NUM_REQ;
            end
            search_idx = IDX_W'(search_sum);
            if (req_valid[search_idx]) begin
                winner    = search_idx;
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (grant) begin
`ifdef ISLAND_SCHED_ROUND_ROBIN_EN
            if (winner == IDX_W'(NUM_REQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= winner + 1'b1;
            end
`else
            ptr_q <= '0;
`endif
        end
    end

endmodule

// File: rtl/island_scheduler.sv
// HDMI data-island sequencer: preamble, guard bands and packet slots inside blanking, with packet-source arbitration.
// Arbitration mode is selected by ISLAND_SCHED_ROUND_ROBIN_EN (see island_arbiter).
module island_scheduler
    import hdmi_island_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_PACKETS  = 18,
    parameter int MIN_CTRL_GAP = 12,
    parameter int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk_pixel,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [11:0]            blank_remaining,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*24-1:0]  req_header,
    input  logic [NUM_REQ*224-1:0] req_sub,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [2:0]             period,
    output logic                   data_island_period,
    output logic [23:0]            header,
    output logic [223:0]           sub,
    output logic [4:0]             packet_count,
    output logic [IDX_W-1:0]       grant_idx
);

    localparam int GAP_W = (MIN_CTRL_GAP > 0) ? $clog2(MIN_CTRL_GAP + 1) : 1;

    island_state_t    state_q;
    island_state_t    state_d;
    logic [4:0]       phase_q;
    logic [4:0]       phase_d;
    logic [GAP_W-1:0] gap_q;
    logic             gap_ok;
    logic             pkt_start;
    logic             continue_ok;
    logic             island_end;
    logic             win_any;
    logic [IDX_W-1:0] win_idx;

    island_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .grant     (pkt_start && win_any),
        .winner    (win_idx),
        .any_valid (win_any)
    );

    // The current IDLE cycle counts toward the gap, so the preamble follows exactly MIN_CTRL_GAP control cycles.
    assign gap_ok = (int'(gap_q) + 1 >= MIN_CTRL_GAP);

    assign continue_ok = enable && win_any
                      && (int'(packet_count) < MAX_PACKETS)
                      && (blank_remaining >= 12'(PACKET_MIN));

    assign island_end = (state_q == ST_TRAIL_GB) && (state_d == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 5'd1;
        pkt_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (enable && win_any && gap_ok && (blank_remaining >= 12'(ISLAND_MIN))) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (phase_q == 5'(PREAMBLE_LEN - 1)) begin
                    state_d = ST_LEAD_GB;
                    phase_d = '0;
                end
            end
            ST_LEAD_GB: begin
                // No abort here: an empty request set still yields one null packet.
                if (phase_q == 5'(GB_LEN - 1)) begin
                    state_d   = ST_PACKET;
                    phase_d   = '0;
                    pkt_start = 1'b1;
                end
            end
            ST_PACKET: begin
                // Phase wraps 31 -> 0 on continuation, keeping the assembler counter aligned.
                if (phase_q == 5'(PACKET_LEN - 1)) begin
                    if (continue_ok) begin
                        pkt_start = 1'b1;
                    end else begin
                        state_d = ST_TRAIL_GB;
                        phase_d = '0;
                    end
                end
            end
            ST_TRAIL_GB: begin
                if (phase_q == 5'(GB_LEN - 1)) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Control: state, phase, period code, gap counter.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            phase_q            <= '0;
            period             <= PERIOD_CTRL;
            data_island_period <= 1'b0;
            gap_q              <= GAP_W'(MIN_CTRL_GAP);
        end else begin
            state_q            <= state_d;
            phase_q            <= phase_d;
            period             <= period_of(state_d);
            data_island_period <= (state_d == ST_PACKET);
            if (island_end) begin
                gap_q <= '0;
            end else if ((state_q == ST_IDLE) && (int'(gap_q) < MIN_CTRL_GAP)) begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

    // Grant: latch the winner's packet, acknowledge it and count it.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            req_ack      <= '0;
            header       <= '0;
            sub          <= '0;
            packet_count <= '0;
            grant_idx    <= '0;
        end else begin
            req_ack <= '0;
            if (pkt_start) begin
                packet_count <= packet_count + 5'd1;
                if (win_any) begin
                    header    <= req_header[win_idx*24 +: 24];
                    sub       <= req_sub[win_idx*224 +: 224];
                    grant_idx <= win_idx;
                    req_ack   <= NUM_REQ'(1) << win_idx;
                end else begin
                    header <= '0;
                    sub    <= '0;
                end
            end else if (island_end) begin
                packet_count <= '0;
            end
        end
    end

endmodule
